// File: rtl/fsb16_pkg.sv
// fsb16_pkg
// Shared definitions for the FSB16 target: the transfer state machine
// encoding, the fsb_size codes and the fixed read turnaround length.
package fsb16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_WR_D0,
        ST_WR_D1,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_D0,
        ST_RD_D1
    } fsb_state_e;

    localparam logic FSB_SIZE_16 = 1'b0;
    localparam logic FSB_SIZE_32 = 1'b1;

    // Idle cycles between the second address cycle and the first read data cycle.
    localparam int FSB_RD_TA_CYCLES = 2;

endpackage

// File: rtl/fsb16_target.sv
// fsb16_target
// Responder end of the FSB16 bus. Decodes the two multiplexed address cycles
// and one or two data cycles into a single-cycle local register port, returns
// read data with a fixed two-cycle turnaround, and forwards a local interrupt.
//
// Ports:
//   hclk, hreset_n      bus clock, synchronous active-low reset
//   fsb_cs, fsb_aen     chip select and address enable
//   fsb_wr_n, fsb_size  direction and width, sampled in the first address cycle
//   fsb_ad_in           AD bus input
//   fsb_ad_out/_oe      AD bus drive value and enable (read data cycles only)
//   fsb_error_n         error flag, active low
//   fsb_irq_n           interrupt, active low
//   reg_addr/_be/_wdata local port address, byte enables, write data
//   reg_wr, reg_rd      single-cycle local write / read strobes
//   reg_rdata, reg_err  local read response, valid the cycle after reg_rd
//   irq_req             local level interrupt request
module fsb16_target
    import fsb16_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 12
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              fsb_cs,
    input  logic              fsb_aen,
    input  logic              fsb_wr_n,
    input  logic              fsb_size,
    input  logic [15:0]       fsb_ad_in,
    output logic [15:0]       fsb_ad_out,
    output logic              fsb_ad_oe,
    output logic              fsb_error_n,
    output logic              fsb_irq_n,
    output logic [ADDR_W-3:0] reg_addr,
    output logic              reg_wr,
    output logic [3:0]        reg_be,
    output logic [31:0]       reg_wdata,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_err,
    input  logic              irq_req
);

    fsb_state_e  state;
    logic [15:0] addr_lo_q;
    logic        size_q;
    logic        wr_n_q;
    logic        hit_q;
    logic        addr_b1_q;
    logic [15:0] wdata_lo_q;
    logic [15:0] rdata_hi_q;
    logic        err_q;
    logic        irq_q;

    logic [31:0] full_addr;
    logic        aligned;
    logic        hit;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [15:0] rd_half;

    // Address decode is only meaningful in ADDR_HI, where fsb_ad_in carries
    // the upper halfword. Read response is only meaningful in RD_WAIT; a miss
    // is answered locally with zero data and an error.
    always_comb begin
        full_addr = {fsb_ad_in, addr_lo_q};
        aligned   = (size_q == FSB_SIZE_32) ? (full_addr[1:0] == 2'b00)
                                            : (full_addr[0] == 1'b0);
        hit       = (full_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]) && aligned;
        rd_data   = hit_q ? reg_rdata : 32'h0000_0000;
        rd_err    = hit_q ? reg_err : 1'b1;
        rd_half   = ((size_q == FSB_SIZE_32) || !addr_b1_q) ? rd_data[15:0]
                                                            : rd_data[31:16];
    end

    // Transfer FSM. Bus outputs default to their idle values every cycle and
    // are only raised on the transition into the state that owns them, which
    // makes every abort and the return to IDLE release the AD bus at once.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state       <= ST_IDLE;
            addr_lo_q   <= '0;
            size_q      <= 1'b0;
            wr_n_q      <= 1'b1;
            hit_q       <= 1'b0;
            addr_b1_q   <= 1'b0;
            wdata_lo_q  <= '0;
            rdata_hi_q  <= '0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
            fsb_ad_out  <= '0;
            fsb_ad_oe   <= 1'b0;
            fsb_error_n <= 1'b1;
            reg_addr    <= '0;
            reg_wr      <= 1'b0;
            reg_be      <= '0;
            reg_wdata   <= '0;
            reg_rd      <= 1'b0;
        end else begin
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            fsb_ad_oe   <= 1'b0;
            fsb_ad_out  <= '0;
            fsb_error_n <= 1'b1;
            irq_q       <= irq_req;

            case (state)
                ST_IDLE: begin
                    if (fsb_cs && fsb_aen) begin
                        addr_lo_q <= fsb_ad_in;
                        size_q    <= fsb_size;
                        wr_n_q    <= fsb_wr_n;
                        state     <= ST_ADDR_HI;
                    end
                end

                ST_ADDR_HI: begin
                    if (fsb_cs && fsb_aen) begin
                        hit_q     <= hit;
                        addr_b1_q <= full_addr[1];
                        reg_addr  <= full_addr[ADDR_W-1:2];
                        if (!wr_n_q) begin
                            fsb_error_n <= hit;
                            state       <= ST_WR_D0;
                        end else begin
                            reg_rd <= hit;
                            state  <= ST_RD_REQ;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WR_D0: begin
                    if (!fsb_cs) begin
                        state <= ST_IDLE;
                    end else if (size_q == FSB_SIZE_32) begin
                        wdata_lo_q  <= fsb_ad_in;
                        fsb_error_n <= hit_q;
                        state       <= ST_WR_D1;
                    end else begin
                        // The strobe lands in the following IDLE cycle, which
                        // may already be the first address cycle of the next transfer.
                        reg_wr <= hit_q;
                        if (hit_q) begin
                            reg_be    <= addr_b1_q ? 4'b1100 : 4'b0011;
                            reg_wdata <= {fsb_ad_in, fsb_ad_in};
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_WR_D1: begin
                    if (fsb_cs) begin
                        reg_wr <= hit_q;
                        if (hit_q) begin
                            reg_be    <= 4'b1111;
                            reg_wdata <= {fsb_ad_in, wdata_lo_q};
                        end
                    end
                    state <= ST_IDLE;
                end

                ST_RD_REQ: begin
                    state <= fsb_cs ? ST_RD_WAIT : ST_IDLE;
                end

                ST_RD_WAIT: begin
                    // The first data halfword is driven straight from the local
                    // response so it is on the bus in the first data cycle.
                    if (fsb_cs) begin
                        rdata_hi_q  <= rd_data[31:16];
                        err_q       <= rd_err;
                        fsb_ad_oe   <= 1'b1;
                        fsb_ad_out  <= rd_half;
                        fsb_error_n <= ~rd_err;
                        state       <= ST_RD_D0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RD_D0: begin
                    if (fsb_cs && (size_q == FSB_SIZE_32)) begin
                        fsb_ad_oe   <= 1'b1;
                        fsb_ad_out  <= rdata_hi_q;
                        fsb_error_n <= ~err_q;
                        state       <= ST_RD_D1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RD_D1: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsb_irq_n = ~irq_q;

endmodule

// File: tb/tb_fsb16_target.sv
// tb_fsb16_target
// Self-checking bench for fsb16_target: a table of directed transfers with
// hand-computed expectations, hand-written abort / back-to-back / reset /
// interrupt sequences, and random transfers predicted by a reference model
// that works from the address-window and byte-lane rules directly.
module tb_fsb16_target;
    import fsb16_pkg::*;

    logic        hclk;
    logic        hreset_n;
    logic        fsb_cs;
    logic        fsb_aen;
    logic        fsb_wr_n;
    logic        fsb_size;
    logic [15:0] fsb_ad_in;
    logic [15:0] fsb_ad_out;
    logic        fsb_ad_oe;
    logic        fsb_error_n;
    logic        fsb_irq_n;
    logic [9:0]  reg_addr;
    logic        reg_wr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_err;
    logic        irq_req;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic        sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic        hit;
        logic [9:0]  raddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [15:0] ad0;
        logic [15:0] ad1;
        logic        errn;
    } txn_t;

    txn_t vecs [10];

    fsb16_target #(
        .BASE_ADDR (32'h0000_0000),
        .ADDR_W    (12)
    ) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .fsb_cs      (fsb_cs),
        .fsb_aen     (fsb_aen),
        .fsb_wr_n    (fsb_wr_n),
        .fsb_size    (fsb_size),
        .fsb_ad_in   (fsb_ad_in),
        .fsb_ad_out  (fsb_ad_out),
        .fsb_ad_oe   (fsb_ad_oe),
        .fsb_error_n (fsb_error_n),
        .fsb_irq_n   (fsb_irq_n),
        .reg_addr    (reg_addr),
        .reg_wr      (reg_wr),
        .reg_be      (reg_be),
        .reg_wdata   (reg_wdata),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_err     (reg_err),
        .irq_req     (irq_req)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle, then step to 1 time unit after the edge so the
    // registered outputs for the following cycle can be observed.
    task automatic applyStimulus(input logic cs, input logic aen, input logic wr_n,
                                 input logic sz, input logic [15:0] ad);
        fsb_cs    = cs;
        fsb_aen   = aen;
        fsb_wr_n  = wr_n;
        fsb_size  = sz;
        fsb_ad_in = ad;
        @(posedge hclk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    // Reference model: window is the first 4 KiB, 32-bit transfers need a
    // multiple of 4, 16-bit ones a multiple of 2.
    function automatic txn_t predict(input logic wr, input logic sz,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     input logic err);
        txn_t        t;
        int unsigned a;
        logic [31:0] rd;
        a       = addr;
        t.wr    = wr;
        t.sz    = sz;
        t.addr  = addr;
        t.data  = data;
        t.err   = err;
        t.hit   = (a / 4096 == 0) && (sz ? (a % 4 == 0) : (a % 2 == 0));
        t.raddr = 10'((a % 4096) / 4);
        t.be    = sz ? 4'hF : (((a / 2) % 2 == 1) ? 4'hC : 4'h3);
        t.wdata = sz ? data : {data[15:0], data[15:0]};
        rd      = t.hit ? data : 32'h0;
        t.ad0   = (sz || ((a / 2) % 2 == 0)) ? rd[15:0] : rd[31:16];
        t.ad1   = rd[31:16];
        t.errn  = wr ? t.hit : !(!t.hit || err);
        return t;
    endfunction

    // One complete transfer with checks at every cycle boundary.
    task automatic runTxn(input string tag, input txn_t t);
        reg_rdata = t.data;
        reg_err   = t.err;
        applyStimulus(1'b1, 1'b1, ~t.wr, t.sz, t.addr[15:0]);
        checkOutput({tag, "_a0_wr"}, 32'(reg_wr), 32'd0);
        applyStimulus(1'b1, 1'b1, ~t.wr, t.sz, t.addr[31:16]);
        if (t.wr) begin
            checkOutput({tag, "_d0_errn"}, 32'(fsb_error_n), 32'(t.errn));
            checkOutput({tag, "_d0_oe"}, 32'(fsb_ad_oe), 32'd0);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, t.data[15:0]);
            if (t.sz) begin
                checkOutput({tag, "_d1_errn"}, 32'(fsb_error_n), 32'(t.errn));
                checkOutput({tag, "_d1_wr"}, 32'(reg_wr), 32'd0);
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, t.data[31:16]);
            end
            checkOutput({tag, "_wr"}, 32'(reg_wr), 32'(t.hit));
            checkOutput({tag, "_end_errn"}, 32'(fsb_error_n), 32'd1);
            if (t.hit) begin
                checkOutput({tag, "_addr"}, 32'(reg_addr), 32'(t.raddr));
                checkOutput({tag, "_be"}, 32'(reg_be), 32'(t.be));
                checkOutput({tag, "_wdata"}, reg_wdata, t.wdata);
            end
        end else begin
            checkOutput({tag, "_rd"}, 32'(reg_rd), 32'(t.hit));
            checkOutput({tag, "_ta_oe"}, 32'(fsb_ad_oe), 32'd0);
            if (t.hit) checkOutput({tag, "_addr"}, 32'(reg_addr), 32'(t.raddr));
            for (int i = 1; i < FSB_RD_TA_CYCLES; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
                checkOutput({tag, "_ta2_oe"}, 32'(fsb_ad_oe), 32'd0);
                checkOutput({tag, "_ta2_rd"}, 32'(reg_rd), 32'd0);
            end
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
            checkOutput({tag, "_d0_oe"}, 32'(fsb_ad_oe), 32'd1);
            checkOutput({tag, "_d0_ad"}, 32'(fsb_ad_out), 32'(t.ad0));
            checkOutput({tag, "_d0_errn"}, 32'(fsb_error_n), 32'(t.errn));
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
            if (t.sz) begin
                checkOutput({tag, "_d1_oe"}, 32'(fsb_ad_oe), 32'd1);
                checkOutput({tag, "_d1_ad"}, 32'(fsb_ad_out), 32'(t.ad1));
                checkOutput({tag, "_d1_errn"}, 32'(fsb_error_n), 32'(t.errn));
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
            end
            checkOutput({tag, "_end_oe"}, 32'(fsb_ad_oe), 32'd0);
            checkOutput({tag, "_end_errn"}, 32'(fsb_error_n), 32'd1);
        end
        idleCycle();
        checkOutput({tag, "_post_wr"}, 32'(reg_wr), 32'd0);
    endtask

    initial begin
        txn_t        t;
        logic [31:0] a;

        //            wr    sz    addr           data           err   hit   raddr   be    wdata          ad0      ad1      errn
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1'b1, 10'h041, 4'hF, 32'hDEAD_BEEF, 16'h0,   16'h0,   1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_1234, 1'b0, 1'b1, 10'h001, 4'hC, 32'h1234_1234, 16'h0,   16'h0,   1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 1'b1, 10'h004, 4'h0, 32'h0,         16'hF00D, 16'hCAFE, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0,         16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0002, 32'h1234_5678, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0,         16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_000A, 32'h5555_AAAA, 1'b1, 1'b1, 10'h002, 4'h0, 32'h0,         16'h5555, 16'h5555, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0BAD_F00D, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0,         16'h0,   16'h0,   1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_BEEF, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0,         16'h0,   16'h0,   1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h8765_4321, 1'b0, 1'b1, 10'h000, 4'h0, 32'h0,         16'h4321, 16'h8765, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_ABCD, 1'b0, 1'b1, 10'h3FF, 4'h3, 32'hABCD_ABCD, 16'h0,   16'h0,   1'b1};

        hreset_n  = 1'b0;
        reg_rdata = 32'h0;
        reg_err   = 1'b0;
        irq_req   = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("rst_oe", 32'(fsb_ad_oe), 32'd0);
        checkOutput("rst_ad", 32'(fsb_ad_out), 32'd0);
        checkOutput("rst_errn", 32'(fsb_error_n), 32'd1);
        checkOutput("rst_irqn", 32'(fsb_irq_n), 32'd1);
        checkOutput("rst_wr", 32'(reg_wr), 32'd0);
        checkOutput("rst_rd", 32'(reg_rd), 32'd0);
        checkOutput("rst_be", 32'(reg_be), 32'd0);
        checkOutput("rst_addr", 32'(reg_addr), 32'd0);
        checkOutput("rst_wdata", reg_wdata, 32'd0);
        hreset_n = 1'b1;
        idleCycle();

        for (int i = 0; i < 10; i++) runTxn($sformatf("vec%0d", i), vecs[i]);

        // Chip select drops in the second write data cycle: no strobe.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h2222);
        checkOutput("abort_wr", 32'(reg_wr), 32'd0);
        checkOutput("abort_errn", 32'(fsb_error_n), 32'd1);
        idleCycle();
        checkOutput("abort_wr2", 32'(reg_wr), 32'd0);
        runTxn("abort_rd", predict(1'b0, 1'b0, 32'h0, 32'h1111_2222, 1'b0));

        // Address enable drops in the second address cycle.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        checkOutput("aen_abort_rd", 32'(reg_rd), 32'd0);
        runTxn("aen_abort_next", predict(1'b0, 1'b1, 32'h40, 32'h0F0F_1234, 1'b0));

        // Back-to-back: a new address is accepted in the strobe cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0008);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA);
        checkOutput("b2b_wr", 32'(reg_wr), 32'd1);
        checkOutput("b2b_be", 32'(reg_be), 32'h3);
        checkOutput("b2b_wdata", reg_wdata, 32'h00AA_00AA);
        checkOutput("b2b_addr", 32'(reg_addr), 32'h2);
        runTxn("b2b_rd", predict(1'b0, 1'b1, 32'h0000_0100, 32'h0123_4567, 1'b0));

        // Interrupt follows irq_req inverted, one cycle later.
        irq_req = 1'b1;
        #1;
        checkOutput("irq_pre", 32'(fsb_irq_n), 32'd1);
        idleCycle();
        checkOutput("irq_set", 32'(fsb_irq_n), 32'd0);
        idleCycle();
        checkOutput("irq_hold", 32'(fsb_irq_n), 32'd0);
        irq_req = 1'b0;
        #1;
        checkOutput("irq_lag", 32'(fsb_irq_n), 32'd0);
        idleCycle();
        checkOutput("irq_clr", 32'(fsb_irq_n), 32'd1);

        // Reset during the first read data cycle (with an error pending).
        reg_rdata = 32'hAAAA_5555;
        reg_err   = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("rstrd_pre_oe", 32'(fsb_ad_oe), 32'd1);
        checkOutput("rstrd_pre_errn", 32'(fsb_error_n), 32'd0);
        hreset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("rstrd_oe", 32'(fsb_ad_oe), 32'd0);
        checkOutput("rstrd_errn", 32'(fsb_error_n), 32'd1);
        checkOutput("rstrd_ad", 32'(fsb_ad_out), 32'd0);
        hreset_n = 1'b1;
        idleCycle();

        // Reset during a 16-bit write data cycle: the pending strobe never fires.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0004);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        hreset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h7777);
        checkOutput("rstwr_wr", 32'(reg_wr), 32'd0);
        checkOutput("rstwr_wdata", reg_wdata, 32'd0);
        hreset_n = 1'b1;
        idleCycle();
        checkOutput("rstwr_wr2", 32'(reg_wr), 32'd0);

        // Random transfers, mostly inside the window, any alignment.
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 5) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            t = predict(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                        $urandom, 1'($urandom_range(0, 1)));
            runTxn($sformatf("rnd%0d", n), t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
